// File: rtl/tdp_ram_be_if.sv
// Bundle of both RAM ports plus the shared collision flag.
// An en pulse is a one-cycle request with no backpressure; vld answers it exactly one cycle later.
interface tdp_ram_be_if #(
    parameter int DW = 16,
    parameter int AW = 5
);
    logic            a_en;
    logic            a_we;
    logic [DW/8-1:0] a_be;
    logic [AW-1:0]   a_addr;
    logic [DW-1:0]   a_din;
    logic [DW-1:0]   a_dout;
    logic            a_vld;

    logic            b_en;
    logic            b_we;
    logic [DW/8-1:0] b_be;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_din;
    logic [DW-1:0]   b_dout;
    logic            b_vld;

    logic            coll;

    modport master (
        output a_en, a_we, a_be, a_addr, a_din,
        output b_en, b_we, b_be, b_addr, b_din,
        input  a_dout, a_vld, b_dout, b_vld, coll
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_din,
        input  b_en, b_we, b_be, b_addr, b_din,
        output a_dout, a_vld, b_dout, b_vld, coll
    );
endinterface

// File: rtl/tdp_ram_be.sv
// True dual-port RAM with byte enables, selectable same-port RDW and fixed-priority
// write-write collision resolution; one-cycle read latency on both ports.
module tdp_ram_be #(
    parameter int DW       = 16,
    parameter int AW       = 5,
    parameter int RDW_MODE = 0,
    parameter int PRIO     = 0
) (
    input  logic        clk,
    input  logic        rst,
    tdp_ram_be_if.slave bus
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    logic          acc_a, acc_b, wr_a, wr_b, same_addr;
    logic [NB-1:0] be_a_w, be_b_w, keep_a, keep_b;
    logic [DW-1:0] old_a, old_b, merged_a, merged_b;
    logic [DW-1:0] a_dout_d, a_dout_q, b_dout_d, b_dout_q;
    logic          a_vld_q, b_vld_q, coll_d, coll_q;

    always_comb begin
        acc_a     = bus.a_en && !rst;
        acc_b     = bus.b_en && !rst;
        // An all-zero byte mask is a pure read, so it never counts as a write.
        wr_a      = acc_a && bus.a_we && (bus.a_be != '0);
        wr_b      = acc_b && bus.b_we && (bus.b_be != '0);
        same_addr = (bus.a_addr == bus.b_addr);
        coll_d    = wr_a && wr_b && same_addr;
        be_a_w    = wr_a ? bus.a_be : '0;
        be_b_w    = wr_b ? bus.b_be : '0;
        keep_a    = be_a_w;
        keep_b    = be_b_w;
        if (coll_d) begin
            if (PRIO == 0) keep_b = be_b_w & ~be_a_w;
            else           keep_a = be_a_w & ~be_b_w;
        end

        old_a    = mem_q[bus.a_addr];
        old_b    = mem_q[bus.b_addr];
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (keep_a[i])                  merged_a[8*i +: 8] = bus.a_din[8*i +: 8];
            else if (same_addr && keep_b[i]) merged_a[8*i +: 8] = bus.b_din[8*i +: 8];
            if (keep_b[i])                  merged_b[8*i +: 8] = bus.b_din[8*i +: 8];
            else if (same_addr && keep_a[i]) merged_b[8*i +: 8] = bus.a_din[8*i +: 8];
        end

        a_dout_d = a_dout_q;
        b_dout_d = b_dout_q;
        // Write-first only applies to a port's own write; a plain read always sees the old word.
        if (acc_a) a_dout_d = (RDW_MODE == 1 && wr_a) ? merged_a : old_a;
        if (acc_b) b_dout_d = (RDW_MODE == 1 && wr_b) ? merged_b : old_b;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (keep_a[i]) mem_q[bus.a_addr][8*i +: 8] <= bus.a_din[8*i +: 8];
            if (keep_b[i]) mem_q[bus.b_addr][8*i +: 8] <= bus.b_din[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
            a_vld_q  <= acc_a;
            b_vld_q  <= acc_b;
            coll_q   <= coll_d;
        end
    end

    assign bus.a_dout = a_dout_q;
    assign bus.b_dout = b_dout_q;
    assign bus.a_vld  = a_vld_q;
    assign bus.b_vld  = b_vld_q;
    assign bus.coll   = coll_q;
endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: two instances (read-first/A-wins and write-first/B-wins) share one
// stimulus stream and are checked every cycle against a word-level memory model.
module tb_tdp_ram_be;
    logic clk = 1'b0;
    logic rst;
    logic        a_en, a_we, b_en, b_we;
    logic [1:0]  a_be, b_be;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdp_ram_be_if #(.DW(16), .AW(5)) if0 ();
    tdp_ram_be_if #(.DW(16), .AW(5)) if1 ();

    assign if0.a_en = a_en;  assign if1.a_en = a_en;
    assign if0.a_we = a_we;  assign if1.a_we = a_we;
    assign if0.a_be = a_be;  assign if1.a_be = a_be;
    assign if0.a_addr = a_addr;  assign if1.a_addr = a_addr;
    assign if0.a_din = a_din;  assign if1.a_din = a_din;
    assign if0.b_en = b_en;  assign if1.b_en = b_en;
    assign if0.b_we = b_we;  assign if1.b_we = b_we;
    assign if0.b_be = b_be;  assign if1.b_be = b_be;
    assign if0.b_addr = b_addr;  assign if1.b_addr = b_addr;
    assign if0.b_din = b_din;  assign if1.b_din = b_din;

    tdp_ram_be #(.DW(16), .AW(5), .RDW_MODE(0), .PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    tdp_ram_be #(.DW(16), .AW(5), .RDW_MODE(1), .PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // ---------------- reference model ----------------
    // Instance p uses RDW_MODE = p and PRIO = p. kn tracks which bytes are known (written).
    logic [15:0] m_mem [2][32];
    logic [1:0]  m_kn  [2][32];
    logic [15:0] e_ad [2], e_bd [2];
    logic [1:0]  e_ak [2], e_bk [2];
    logic        e_av [2], e_bv [2], e_coll [2];
    logic        chk_en = 1'b0;

    function automatic void mwrite(int p, logic [4:0] ad, logic [1:0] be, logic [15:0] d);
        if (be[0]) begin m_mem[p][ad][7:0]  = d[7:0];  m_kn[p][ad][0] = 1'b1; end
        if (be[1]) begin m_mem[p][ad][15:8] = d[15:8]; m_kn[p][ad][1] = 1'b1; end
    endfunction

    initial begin
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 32; i++) begin m_mem[p][i] = '0; m_kn[p][i] = 2'b00; end
    end

    always @(posedge clk) begin
        logic        wa, wb;
        logic [15:0] oa, ob;
        logic [1:0]  ka, kb;
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                e_ad[p] = '0; e_bd[p] = '0; e_ak[p] = 2'b11; e_bk[p] = 2'b11;
                e_av[p] = 1'b0; e_bv[p] = 1'b0; e_coll[p] = 1'b0;
            end else begin
                wa = a_en && a_we && (a_be != 2'b00);
                wb = b_en && b_we && (b_be != 2'b00);
                oa = m_mem[p][a_addr]; ka = m_kn[p][a_addr];
                ob = m_mem[p][b_addr]; kb = m_kn[p][b_addr];
                // The winner is applied last so it overwrites shared bytes.
                if (p == 0) begin
                    if (wb) mwrite(p, b_addr, b_be, b_din);
                    if (wa) mwrite(p, a_addr, a_be, a_din);
                end else begin
                    if (wa) mwrite(p, a_addr, a_be, a_din);
                    if (wb) mwrite(p, b_addr, b_be, b_din);
                end
                e_coll[p] = wa && wb && (a_addr == b_addr);
                e_av[p] = a_en;
                e_bv[p] = b_en;
                if (a_en) begin
                    e_ad[p] = (p == 1 && wa) ? m_mem[p][a_addr] : oa;
                    e_ak[p] = (p == 1 && wa) ? m_kn[p][a_addr]  : ka;
                end
                if (b_en) begin
                    e_bd[p] = (p == 1 && wb) ? m_mem[p][b_addr] : ob;
                    e_bk[p] = (p == 1 && wb) ? m_kn[p][b_addr]  : kb;
                end
            end
        end
        chk_en = 1'b1;
    end

    // ---------------- comparisons ----------------
    function automatic logic [15:0] m16(logic [1:0] k);
        return {{8{k[1]}}, {8{k[0]}}};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input int p, input logic [15:0] ad, input logic [15:0] bd,
                            input logic av, input logic bv, input logic c);
        chk($sformatf("u%0d_a_vld", p), {15'b0, av}, {15'b0, e_av[p]});
        chk($sformatf("u%0d_b_vld", p), {15'b0, bv}, {15'b0, e_bv[p]});
        chk($sformatf("u%0d_coll", p),  {15'b0, c},  {15'b0, e_coll[p]});
        if (e_ak[p] != 2'b00) chk($sformatf("u%0d_a_dout", p), ad & m16(e_ak[p]), e_ad[p] & m16(e_ak[p]));
        if (e_bk[p] != 2'b00) chk($sformatf("u%0d_b_dout", p), bd & m16(e_bk[p]), e_bd[p] & m16(e_bk[p]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, if0.a_dout, if0.b_dout, if0.a_vld, if0.b_vld, if0.coll);
            cmp_inst(1, if1.a_dout, if1.b_dout, if1.a_vld, if1.b_vld, if1.coll);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r,
                        input logic ae, input logic awe, input logic [1:0] abe,
                        input logic [4:0] aad, input logic [15:0] ad,
                        input logic be_, input logic bwe, input logic [1:0] bbe,
                        input logic [4:0] bad, input logic [15:0] bd);
        rst = r;
        a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_din = ad;
        b_en = be_; b_we = bwe; b_be = bbe; b_addr = bad; b_din = bd;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    endtask

    initial begin
        logic [4:0] pa;
        step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);

        // Reset blocks writes and zeroes outputs; memory keeps its old word.
        step(1'b0, 1'b1, 1'b1, 2'b11, 5'd3, 16'h0BAD, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 2'b11, 5'd3, 16'hDEAD, 1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
            chk("rst_a_dout", if0.a_dout, 16'h0000);
            chk("rst_vld", {14'b0, if0.a_vld, if0.b_vld}, 16'h0000);
        end
        step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
        chk("rst_keep_mem", if0.b_dout, 16'h0BAD);
        chk("rst_keep_vld", {15'b0, if0.b_vld}, 16'h0001);

        // Byte-enable write
        step(1'b0, 1'b1, 1'b1, 2'b11, 5'd7, 16'h1234, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 1'b1, 2'b01, 5'd7, 16'hABCD);
        step(1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 16'h0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        chk("be_merge_u0", if0.a_dout, 16'h12CD);
        chk("be_merge_u1", if1.a_dout, 16'h12CD);

        // Same-port read-during-write
        step(1'b0, 1'b1, 1'b1, 2'b11, 5'd4, 16'h0001, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 2'b11, 5'd4, 16'h00FF, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        chk("rdw_read_first", if0.a_dout, 16'h0001);
        chk("rdw_write_first", if1.a_dout, 16'h00FF);

        // Cross-port read-during-write
        step(1'b0, 1'b1, 1'b1, 2'b11, 5'd9, 16'h5555, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 2'b11, 5'd9, 16'hAAAA, 1'b1, 1'b0, 2'b00, 5'd9, 16'h0);
        chk("xrdw_old_u0", if0.b_dout, 16'h5555);
        chk("xrdw_old_u1", if1.b_dout, 16'h5555);
        step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 1'b0, 2'b00, 5'd9, 16'h0);
        chk("xrdw_new", if0.b_dout, 16'hAAAA);

        // Write-write collision
        step(1'b0, 1'b1, 1'b1, 2'b11, 5'd0, 16'h1111, 1'b1, 1'b1, 2'b10, 5'd0, 16'h2222);
        chk("coll_pulse_u0", {15'b0, if0.coll}, 16'h0001);
        chk("coll_pulse_u1", {15'b0, if1.coll}, 16'h0001);
        chk("coll_loser_wf", if1.a_dout, 16'h2211);
        step(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        chk("coll_once", {14'b0, if0.coll, if1.coll}, 16'h0000);
        chk("coll_prio_a", if0.a_dout, 16'h1111);
        chk("coll_prio_b", if1.a_dout, 16'h2211);

        // Throughput: B reads what A wrote on the previous cycle
        for (int i = 0; i < 32; i++) begin
            pa = 5'(i) - 5'd1;
            step(1'b0, 1'b1, 1'b1, 2'b11, 5'(i), 16'(i) + 16'h100, 1'b1, 1'b0, 2'b00, pa, 16'h0);
            if (i > 0) chk("thru_b", if0.b_dout, 16'(i - 1) + 16'h100);
        end
        idle();
        chk("idle_vld", {12'b0, if0.a_vld, if0.b_vld, if1.a_vld, if1.b_vld}, 16'h0000);
        chk("idle_hold_b", if0.b_dout, 16'h011E);
        chk("idle_hold_a_wf", if1.a_dout, 16'h011F);
        idle();
        chk("idle_hold_b2", if1.b_dout, 16'h011E);

        // Randomized traffic over a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 5'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 5'($urandom_range(0, 3)), 16'($urandom));
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tdp_ram_be.md
# tdp_ram_be

Parametrised true dual-port synchronous RAM with per-byte write enables, selectable same-port read-during-write behaviour, deterministic write-write collision resolution and a registered collision flag. It is the next-generation shared memory for datapath blocks that need two independent read/write ports into one array, such as packet buffers, coefficient tables and scratchpads. Both ports run on a single clock, and each has one cycle of read latency with a data-valid strobe.

## Interface
- `DW`, default 16: data width in bits. Must be a multiple of 8.
- `AW`, default 5: address width. Depth is 2^AW words.
- `RDW_MODE`, default 0: same-port read-during-write behaviour. 0 = read-first (returns old word); 1 = write-first (returns newly written word).
- `PRIO`, default 0: write-write collision winner. 0 = port A wins; 1 = port B wins.

Clock and reset:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.

Port A (port B is identical, with `b_` prefix):
- `a_en`  in  1  access enable.
- `a_we`  in  1  write enable. Qualified by `a_en`.
- `a_be`  in  DW/8  byte enables. Bit i covers `a_din[8i+7:8i]`.
- `a_addr`  in  AW  word address.
- `a_din`  in  DW  write data.
- `a_dout`  out  DW  registered read data.
- `a_vld`  out  1  high for exactly the cycle after an accepted access.

Shared:
- `coll`  out  1  one-cycle pulse, registered, indicating a write-write collision.

## Operation
- An access on a port is accepted when `x_en`=1 and `rst`=0.
- Every accepted access reads `mem[x_addr]`. This applies to writes as well as reads.
- Writes:
  - An accepted access with `x_we`=1 updates only the bytes whose `x_be` bit is 1.
  - `x_we`=1 with `x_be`=0 is a pure read and does not write.
- Same-port read-during-write:
  - `RDW_MODE`=0: `x_dout` shows the pre-write word.
  - `RDW_MODE`=1: `x_dout` shows the merged word, i.e. old bytes where `be`=0 and new bytes where `be`=1.
- Cross-port read-during-write: port X reads address N while port Y writes N in the same cycle.
  - X always gets the pre-write word, independent of `RDW_MODE`.
- Write-write collision: both ports write the same address in the same cycle.
  - Bytes enabled on only one port take that port's data.
  - Bytes enabled on both ports take the `PRIO` winner's data.
  - The loser's own `dout` follows its `RDW_MODE` rule applied to the final merged word when `RDW_MODE`=1, and the old word when `RDW_MODE`=0.
  - `coll` pulses the next cycle, even if the byte-enable sets are disjoint.
- Writes to different addresses on the two ports are fully independent.
- Idle port (`x_en`=0):
  - `x_dout` holds its last value.
  - `x_vld`=0.
  - No memory effect.
- `rst`=1:
  - All accesses are blocked, including writes.
  - `a_dout`, `b_dout` = 0; `a_vld`, `b_vld`, `coll` = 0.
  - Memory contents are not cleared and retain their pre-reset values.
- Reset asserted mid-burst: the access presented in the reset cycle is dropped and produces no `vld`. Operation resumes on the first cycle with `rst`=0.
- Initial memory contents are undefined until written. The bench must write before reading.

## Timing
- Read latency is 1: access at edge k gives `x_dout` and `x_vld`=1 valid after edge k, i.e. during cycle k+1.
- Write takes effect at edge k. A read of the same address at edge k+1 on either port returns the new data.
- `coll` is asserted during cycle k+1 for a collision presented at edge k, for exactly one cycle per colliding edge.
- Back-to-back accesses on every cycle are supported on both ports simultaneously. There is no stall and no backpressure.
- Address and data are sampled only at edges where the access is accepted. Values outside those edges are don't-care.

## Test plan
- **Reset state.** Assert `rst` for 2 cycles with `a_en`=`b_en`=1 and `a_we`=1, `a_addr`=3, `a_din`=16'hDEAD, `a_be`=2'b11; then release and read address 3 on port B.
  - Required: during reset all outputs are 0 and `vld`=0.
  - Required: the read does not return 16'hDEAD unless the bench pre-wrote that value.
- **Byte-enable write.** Write 16'h1234 with `be`=2'b11 to address 7 on A, then 16'hABCD with `be`=2'b01 to address 7 on B, then read 7 on A.
  - Required: `a_dout`=16'h12CD with `a_vld`=1 one cycle after the read.
- **Same-port RDW.** With address 4 holding 16'h0001, write 16'h00FF with `be`=2'b11 on A.
  - Required: `RDW_MODE`=0 gives `a_dout`=16'h0001.
  - Required: `RDW_MODE`=1 gives `a_dout`=16'h00FF.
- **Cross-port RDW.** With address 9 holding 16'h5555, in one cycle A writes 16'hAAAA to 9 while B reads 9.
  - Required: `b_dout`=16'h5555.
  - Required: a read of 9 on the next cycle returns 16'hAAAA.
- **Collision.** With `PRIO`=0, A writes 16'h1111 with `be`=2'b11 and B writes 16'h2222 with `be`=2'b10 to address 0 in the same cycle.
  - Required: `coll`=1 for exactly one cycle.
  - Required: address 0 then reads 16'h1111.
  - Repeat with `PRIO`=1. Required: address 0 reads 16'h2211.
- **Throughput and idle.** Run 32 consecutive writes of `addr`+16'h100 on A while B reads `addr`-1 on every cycle, then deassert `en` on both ports.
  - Required: B returns each value one cycle after it was written.
  - Required: after `en` is deasserted, `vld` drops to 0 and `dout` holds its last value.
